// File: rtl/ddr3_cmd_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_cmd_arb_if
//  Description : Signal bundle for the DDR3 command arbiter. It carries the
//                config/refresh port, the controller command port and the
//                registered DFI command pins.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ddr3_cmd_arb_if #(
  parameter int DDR_ROW_BITS = 13
);
  // Config / refresh port
  logic                    cfg_req_i;
  logic                    cfg_rdy_o;
  logic                    cfg_run_i;
  logic                    cfg_ref_i;
  logic [2:0]              cfg_cmd_i;
  logic [2:0]              cfg_ba_i;
  logic [DDR_ROW_BITS-1:0] cfg_adr_i;
  logic                    ref_ack_o;

  // Memory-controller command port
  logic                    mem_valid_i;
  logic                    mem_ready_o;
  logic [2:0]              mem_cmd_i;
  logic [2:0]              mem_ba_i;
  logic [DDR_ROW_BITS-1:0] mem_adr_i;

  // DFI command pins
  logic                    dfi_ras_no;
  logic                    dfi_cas_no;
  logic                    dfi_we_no;
  logic [2:0]              dfi_ba_o;
  logic [DDR_ROW_BITS-1:0] dfi_adr_o;

  // Arbiter side
  modport slave (
    input  cfg_req_i, cfg_run_i, cfg_ref_i, cfg_cmd_i, cfg_ba_i, cfg_adr_i,
    input  mem_valid_i, mem_cmd_i, mem_ba_i, mem_adr_i,
    output cfg_rdy_o, ref_ack_o, mem_ready_o,
    output dfi_ras_no, dfi_cas_no, dfi_we_no, dfi_ba_o, dfi_adr_o
  );

  // Upstream sources / pin observer side
  modport master (
    output cfg_req_i, cfg_run_i, cfg_ref_i, cfg_cmd_i, cfg_ba_i, cfg_adr_i,
    output mem_valid_i, mem_cmd_i, mem_ba_i, mem_adr_i,
    input  cfg_rdy_o, ref_ack_o, mem_ready_o,
    input  dfi_ras_no, dfi_cas_no, dfi_we_no, dfi_ba_o, dfi_adr_o
  );
endinterface
`default_nettype wire

// File: rtl/ddr3_cmd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_cmd_arb
//  Description : DDR3 command arbiter. Forwards init commands before run,
//                controller commands after run, inserts PRECHARGE-all and
//                REFRESH on request, tracks open banks and enforces the
//                minimum command gaps (tRP, tRFC, tMOD, tZQinit).
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr3_cmd_arb #(
  parameter int DDR_ROW_BITS   = 13,
  parameter int CYCLES_TRP     = 2,
  parameter int CYCLES_TRFC    = 11,
  parameter int CYCLES_TMOD    = 12,
  parameter int CYCLES_TZQINIT = 512
) (
  input  wire logic     clock,
  input  wire logic     reset,
  ddr3_cmd_arb_if.slave bus
);

  localparam int RSB = DDR_ROW_BITS - 1;

  // {RAS#,CAS#,WE#} encodings
  localparam logic [2:0] c_CMD_NOP  = 3'b111;
  localparam logic [2:0] c_CMD_ACT  = 3'b011;
  localparam logic [2:0] c_CMD_RD   = 3'b101;
  localparam logic [2:0] c_CMD_WR   = 3'b100;
  localparam logic [2:0] c_CMD_PRE  = 3'b010;
  localparam logic [2:0] c_CMD_REF  = 3'b001;
  localparam logic [2:0] c_CMD_MRS  = 3'b000;
  localparam logic [2:0] c_CMD_ZQCL = 3'b110;

  // Gap counter wide enough for the longest of the four timing gaps
  localparam int c_GAP_MAX_A = (CYCLES_TRP  > CYCLES_TRFC)    ? CYCLES_TRP  : CYCLES_TRFC;
  localparam int c_GAP_MAX_B = (CYCLES_TMOD > CYCLES_TZQINIT) ? CYCLES_TMOD : CYCLES_TZQINIT;
  localparam int c_GAP_MAX   = (c_GAP_MAX_A > c_GAP_MAX_B)    ? c_GAP_MAX_A : c_GAP_MAX_B;
  localparam int c_GAP_W     = $clog2(c_GAP_MAX + 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WRP  = 2'd2,
    ST_WRFC = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_GAP_W-1:0] r_gap;
  logic [7:0]         r_banks;
  logic [7:0]         w_banks_nxt;
  // Low while in reset and for the first edge after it, so no handshake
  // output can be asserted while reset is held.
  logic               r_live;

  logic               w_gap_zero;
  logic               w_issue;
  logic [2:0]         w_cmd;
  logic [2:0]         w_ba;
  logic [RSB:0]       w_adr;
  logic               w_cfg_rdy;
  logic               w_mem_ready;
  logic               w_ref_ack;

  logic               r_ras_n;
  logic               r_cas_n;
  logic               r_we_n;
  logic [2:0]         r_ba;
  logic [RSB:0]       r_adr;

  assign w_gap_zero = (r_gap == '0);

  // Gap to enforce after a given command has been issued
  function automatic logic [c_GAP_W-1:0] gap_for(input logic [2:0] cmd);
    case (cmd)
      c_CMD_PRE:  gap_for = c_GAP_W'(CYCLES_TRP);
      c_CMD_REF:  gap_for = c_GAP_W'(CYCLES_TRFC);
      c_CMD_MRS:  gap_for = c_GAP_W'(CYCLES_TMOD);
      c_CMD_ZQCL: gap_for = c_GAP_W'(CYCLES_TZQINIT);
      default:    gap_for = '0;
    endcase
  endfunction

  // Next state, command selection, handshakes and open-bank bookkeeping
  always_comb begin
    w_state_nxt = r_state;
    w_banks_nxt = r_banks;
    w_issue     = 1'b0;
    w_cmd       = c_CMD_NOP;
    w_ba        = '0;
    w_adr       = '0;
    w_cfg_rdy   = 1'b0;
    w_mem_ready = 1'b0;
    w_ref_ack   = 1'b0;

    case (r_state)
      ST_INIT: begin
        w_cfg_rdy = r_live && w_gap_zero && !bus.cfg_run_i;
        if (bus.cfg_req_i && w_cfg_rdy) begin
          w_issue = 1'b1;
          w_cmd   = bus.cfg_cmd_i;
          w_ba    = bus.cfg_ba_i;
          w_adr   = bus.cfg_adr_i;
        end
        if (bus.cfg_run_i) begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (!bus.cfg_run_i) begin
          w_state_nxt = ST_INIT;
          w_banks_nxt = '0;
        end else begin
          w_mem_ready = w_gap_zero && !bus.cfg_ref_i;
          if (bus.cfg_ref_i && w_gap_zero) begin
            w_issue = 1'b1;
            if (r_banks != '0) begin
              // Precharge-all first: bank 0, A10 set
              w_cmd       = c_CMD_PRE;
              w_adr[10]   = 1'b1;
              w_banks_nxt = '0;
              w_state_nxt = ST_WRP;
            end else begin
              w_cmd       = c_CMD_REF;
              w_ref_ack   = 1'b1;
              w_state_nxt = ST_WRFC;
            end
          end else if (bus.mem_valid_i && w_mem_ready) begin
            w_issue = 1'b1;
            w_cmd   = bus.mem_cmd_i;
            w_ba    = bus.mem_ba_i;
            w_adr   = bus.mem_adr_i;
            case (bus.mem_cmd_i)
              c_CMD_ACT: w_banks_nxt[bus.mem_ba_i] = 1'b1;
              c_CMD_PRE: begin
                if (bus.mem_adr_i[10]) w_banks_nxt = '0;
                else                   w_banks_nxt[bus.mem_ba_i] = 1'b0;
              end
              c_CMD_RD, c_CMD_WR: begin
                if (bus.mem_adr_i[10]) w_banks_nxt[bus.mem_ba_i] = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end

      ST_WRP: begin
        if (!bus.cfg_run_i) begin
          w_state_nxt = ST_INIT;
          w_banks_nxt = '0;
        end else if (w_gap_zero) begin
          w_issue     = 1'b1;
          w_cmd       = c_CMD_REF;
          w_ref_ack   = 1'b1;
          w_state_nxt = ST_WRFC;
        end
      end

      ST_WRFC: begin
        if (!bus.cfg_run_i) begin
          w_state_nxt = ST_INIT;
          w_banks_nxt = '0;
        end else if (w_gap_zero) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_INIT;
    endcase
  end

  // State, gap counter and open-bank register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_gap   <= '0;
      r_banks <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_banks <= w_banks_nxt;
      r_live  <= 1'b1;
      if (w_issue)          r_gap <= gap_for(w_cmd);
      else if (!w_gap_zero) r_gap <= r_gap - 1'b1;
    end
  end

  // Registered DFI pins: one-cycle command, NOP otherwise, ba/adr held
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ras_n <= 1'b1;
      r_cas_n <= 1'b1;
      r_we_n  <= 1'b1;
      r_ba    <= '0;
      r_adr   <= '0;
    end else if (w_issue) begin
      {r_ras_n, r_cas_n, r_we_n} <= w_cmd;
      r_ba    <= w_ba;
      r_adr   <= w_adr;
    end else begin
      {r_ras_n, r_cas_n, r_we_n} <= c_CMD_NOP;
    end
  end

  assign bus.cfg_rdy_o   = w_cfg_rdy;
  assign bus.mem_ready_o = w_mem_ready;
  assign bus.ref_ack_o   = w_ref_ack;
  assign bus.dfi_ras_no  = r_ras_n;
  assign bus.dfi_cas_no  = r_cas_n;
  assign bus.dfi_we_no   = r_we_n;
  assign bus.dfi_ba_o    = r_ba;
  assign bus.dfi_adr_o   = r_adr;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_cmd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr3_cmd_arb
//  Description : Directed self-checking bench for ddr3_cmd_arb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_cmd_arb;

  localparam logic [2:0] c_NOP  = 3'b111;
  localparam logic [2:0] c_ACT  = 3'b011;
  localparam logic [2:0] c_RD   = 3'b101;
  localparam logic [2:0] c_PRE  = 3'b010;
  localparam logic [2:0] c_REF  = 3'b001;
  localparam logic [2:0] c_MRS  = 3'b000;
  localparam logic [2:0] c_ZQCL = 3'b110;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clock = ~clock;

  ddr3_cmd_arb_if #(.DDR_ROW_BITS(13)) bus ();

  ddr3_cmd_arb #(
    .DDR_ROW_BITS  (13),
    .CYCLES_TRP    (2),
    .CYCLES_TRFC   (11),
    .CYCLES_TMOD   (12),
    .CYCLES_TZQINIT(512)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Compare one observed value against its expectation
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] pins();
    return {bus.dfi_ras_no, bus.dfi_cas_no, bus.dfi_we_no};
  endfunction

  initial begin
    bus.cfg_req_i   = 1'b0;
    bus.cfg_run_i   = 1'b0;
    bus.cfg_ref_i   = 1'b0;
    bus.cfg_cmd_i   = c_NOP;
    bus.cfg_ba_i    = '0;
    bus.cfg_adr_i   = '0;
    bus.mem_valid_i = 1'b0;
    bus.mem_cmd_i   = c_NOP;
    bus.mem_ba_i    = '0;
    bus.mem_adr_i   = '0;

    // Reset state
    step(); step();
    check("rst_pins", 32'(pins()), 32'(c_NOP));
    check("rst_ba", 32'(bus.dfi_ba_o), 0);
    check("rst_adr", 32'(bus.dfi_adr_o), 0);
    check("rst_cfg_rdy", 32'(bus.cfg_rdy_o), 0);
    check("rst_mem_rdy", 32'(bus.mem_ready_o), 0);
    check("rst_ref_ack", 32'(bus.ref_ack_o), 0);
    reset = 1'b0;
    step();
    check("init_cfg_rdy", 32'(bus.cfg_rdy_o), 1);

    // MRS then tMOD gap
    bus.cfg_req_i = 1'b1; bus.cfg_cmd_i = c_MRS; bus.cfg_ba_i = 3'd2; bus.cfg_adr_i = 13'h123;
    step();
    bus.cfg_req_i = 1'b0;
    check("mrs_pins", 32'(pins()), 32'(c_MRS));
    check("mrs_ba", 32'(bus.dfi_ba_o), 2);
    check("mrs_adr", 32'(bus.dfi_adr_o), 32'h123);
    n = 0;
    while (!bus.cfg_rdy_o && n < 100) begin step(); n++; end
    check("tmod_gap", 32'(n), 12);
    check("nop_after_mrs", 32'(pins()), 32'(c_NOP));
    check("ba_hold", 32'(bus.dfi_ba_o), 2);

    // ZQCL then tZQinit gap
    bus.cfg_req_i = 1'b1; bus.cfg_cmd_i = c_ZQCL; bus.cfg_ba_i = 3'd0; bus.cfg_adr_i = 13'h400;
    step();
    bus.cfg_req_i = 1'b0;
    check("zqcl_pins", 32'(pins()), 32'(c_ZQCL));
    n = 0;
    while (!bus.cfg_rdy_o && n < 2000) begin step(); n++; end
    check("tzqinit_gap", 32'(n), 512);

    // Enter run mode
    bus.cfg_run_i = 1'b1;
    #1;
    check("run_cfg_rdy_init", 32'(bus.cfg_rdy_o), 0);
    step();
    check("run_cfg_rdy_idle", 32'(bus.cfg_rdy_o), 0);
    check("run_mem_rdy", 32'(bus.mem_ready_o), 1);

    // ACT bank 2, then refresh needs PRE-all first
    bus.mem_valid_i = 1'b1; bus.mem_cmd_i = c_ACT; bus.mem_ba_i = 3'd2; bus.mem_adr_i = 13'h055;
    step();
    bus.mem_valid_i = 1'b0;
    check("act_pins", 32'(pins()), 32'(c_ACT));
    check("act_ba", 32'(bus.dfi_ba_o), 2);
    check("act_adr", 32'(bus.dfi_adr_o), 32'h055);
    bus.cfg_ref_i = 1'b1;
    #1;
    check("ref_blocks_mem", 32'(bus.mem_ready_o), 0);
    check("no_ack_before_pre", 32'(bus.ref_ack_o), 0);
    step();
    check("pre_pins", 32'(pins()), 32'(c_PRE));
    check("pre_ba", 32'(bus.dfi_ba_o), 0);
    check("pre_adr", 32'(bus.dfi_adr_o), 32'h400);
    n = 0;
    while (!bus.ref_ack_o && n < 50) begin step(); n++; end
    check("trp_gap", 32'(n), 2);
    step();
    bus.cfg_ref_i = 1'b0;
    check("ref_pins", 32'(pins()), 32'(c_REF));
    check("ack_single", 32'(bus.ref_ack_o), 0);
    n = 0;
    while (!bus.mem_ready_o && n < 100) begin step(); n++; end
    check("trfc_gap", 32'(n), 12);

    // All banks closed: REF straight away
    bus.cfg_ref_i = 1'b1;
    #1;
    check("direct_ack", 32'(bus.ref_ack_o), 1);
    step();
    bus.cfg_ref_i = 1'b0;
    check("direct_ref_pins", 32'(pins()), 32'(c_REF));
    check("direct_ack_drop", 32'(bus.ref_ack_o), 0);
    n = 0;
    while (!bus.mem_ready_o && n < 100) begin step(); n++; end
    check("direct_trfc", 32'(n), 12);

    // Refresh wins over a simultaneous controller command
    bus.mem_valid_i = 1'b1; bus.mem_cmd_i = c_ACT; bus.mem_ba_i = 3'd5; bus.mem_adr_i = 13'h0aa;
    bus.cfg_ref_i = 1'b1;
    #1;
    check("simul_mem_rdy", 32'(bus.mem_ready_o), 0);
    check("simul_ack", 32'(bus.ref_ack_o), 1);
    step();
    bus.cfg_ref_i = 1'b0;
    check("simul_ref_pins", 32'(pins()), 32'(c_REF));
    n = 0;
    while (!bus.mem_ready_o && n < 100) begin step(); n++; end
    check("simul_wait", 32'(n), 12);
    step();
    bus.mem_valid_i = 1'b0;
    check("simul_act_pins", 32'(pins()), 32'(c_ACT));
    check("simul_act_ba", 32'(bus.dfi_ba_o), 5);

    // Auto-precharge closes banks 5 and 3; refresh then needs no PRE
    bus.mem_valid_i = 1'b1; bus.mem_cmd_i = c_RD; bus.mem_ba_i = 3'd5; bus.mem_adr_i = 13'h400;
    step();
    bus.mem_cmd_i = c_ACT; bus.mem_ba_i = 3'd3; bus.mem_adr_i = 13'h011;
    step();
    bus.mem_cmd_i = c_RD; bus.mem_ba_i = 3'd3; bus.mem_adr_i = 13'h410;
    step();
    bus.mem_valid_i = 1'b0;
    check("ap_rd_pins", 32'(pins()), 32'(c_RD));
    bus.cfg_ref_i = 1'b1;
    #1;
    check("ap_direct_ack", 32'(bus.ref_ack_o), 1);
    step();
    bus.cfg_ref_i = 1'b0;
    check("ap_ref_pins", 32'(pins()), 32'(c_REF));
    n = 0;
    while (!bus.mem_ready_o && n < 100) begin step(); n++; end

    // Reset asserted mid-stream
    bus.mem_valid_i = 1'b1; bus.mem_cmd_i = c_ACT; bus.mem_ba_i = 3'd6; bus.mem_adr_i = 13'h1ff;
    step();
    bus.mem_valid_i = 1'b0;
    check("pre_rst_act", 32'(pins()), 32'(c_ACT));
    reset = 1'b1;
    #1;
    check("async_rst_pins", 32'(pins()), 32'(c_NOP));
    check("async_rst_ba", 32'(bus.dfi_ba_o), 0);
    check("async_rst_adr", 32'(bus.dfi_adr_o), 0);
    check("async_rst_mem_rdy", 32'(bus.mem_ready_o), 0);
    check("async_rst_cfg_rdy", 32'(bus.cfg_rdy_o), 0);
    check("async_rst_ack", 32'(bus.ref_ack_o), 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ddr3_cmd_arb.md
Name: ddr3_cmd_arb

Overview:
- Sits directly downstream of the DDR3 configuration/refresh block and upstream of the DFI command pins.
- Before run: forwards initialisation commands (MRS, ZQCL, PRE, REF) from the config port.
- After run: forwards memory-controller commands, tracks open banks, and services refresh requests (PRECHARGE-all when needed, then REFRESH).
- Enforces minimum command gaps (tRP, tRFC, tMOD, tZQinit) so neither upstream source must.

Parameters:
- DDR_ROW_BITS, 13, row/address width; RSB = DDR_ROW_BITS-1.
- CYCLES_TRP, 2, post-PRE gap in clocks.
- CYCLES_TRFC, 11, post-REF gap.
- CYCLES_TMOD, 12, post-MRS gap.
- CYCLES_TZQINIT, 512, post-ZQCL gap.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_req_i  in  1  config command valid (init phase).
- cfg_rdy_o  out  1  config command accepted when cfg_req_i & cfg_rdy_o.
- cfg_run_i  in  1  initialisation complete; controller traffic enabled.
- cfg_ref_i  in  1  refresh pending (level).
- cfg_cmd_i  in  3  {RAS#,CAS#,WE#} command.
- cfg_ba_i  in  3  bank.
- cfg_adr_i  in  RSB+1  address.
- ref_ack_o  out  1  one-cycle pulse when REF is issued in run mode.
- mem_valid_i  in  1  controller command valid.
- mem_ready_o  out  1  controller command accepted when valid & ready.
- mem_cmd_i  in  3  {RAS#,CAS#,WE#}.
- mem_ba_i  in  3  bank.
- mem_adr_i  in  RSB+1  address.
- dfi_ras_no  out  1  registered RAS#.
- dfi_cas_no  out  1  registered CAS#.
- dfi_we_no  out  1  registered WE#.
- dfi_ba_o  out  3  registered bank.
- dfi_adr_o  out  RSB+1  registered address.

Behaviour:
- Encoding {ras,cas,we}: NOP 111, ACT 011, RD 101, WR 100, PRE 010, REF 001, MRS 000, ZQCL 110.
- Reset (async) values:
  - dfi_*_no = 1 (NOP); dfi_ba_o = 0; dfi_adr_o = 0.
  - ref_ack_o = 0; cfg_rdy_o = 0; mem_ready_o = 0.
  - state = ST_INIT; gap = 0; open_banks = 8'h00.
- DFI outputs are registered:
  - An accepted/generated command appears on the pins the cycle after acceptance and lasts exactly one cycle.
  - NOP otherwise; ba/adr hold their last value.
- Gap counter:
  - Loaded on every issued command: PRE→CYCLES_TRP, REF→CYCLES_TRFC, MRS→CYCLES_TMOD, ZQCL→CYCLES_TZQINIT, others→0.
  - Decrements to 0; a new command may issue only when gap==0.
  - G=0 allows back-to-back commands; otherwise the next command issues ≥G+1 cycles later.
- open_banks[7:0] (run mode):
  - ACT sets bit ba.
  - PRE clears bit ba, or all bits if adr[10]=1.
  - RD/WR with adr[10]=1 (auto-precharge) clears bit ba.
- States:
  - ST_INIT:
    - cfg_rdy_o = (gap==0) & !cfg_run_i (combinational).
    - mem_ready_o = 0.
    - cfg_run_i=1 → ST_IDLE.
  - ST_IDLE:
    - mem_ready_o = (gap==0) & !cfg_ref_i.
    - If cfg_ref_i & gap==0: open_banks≠0 → issue PRE (ba=0, adr=1<<10), go ST_WRP; else issue REF, go ST_WRFC.
    - Refresh beats a simultaneous mem_valid_i (mem not accepted that cycle).
  - ST_WRP: gap==0 → issue REF, go ST_WRFC.
  - ST_WRFC: gap==0 → ST_IDLE.
- ref_ack_o pulses in the cycle REF is accepted internally, i.e. one cycle before it appears on the pins.
- cfg_rdy_o = 0 in all run states.
- cfg_run_i falling in any run state:
  - Return to ST_INIT; clear open_banks.
  - Any gap in progress still completes.
- Config-port commands in ST_INIT do not update open_banks.

Test Plan:
- Reset asserted mid-stream → pins at NOP/0 within the same cycle; ref_ack_o=0, mem_ready_o=0, cfg_rdy_o=0 while reset is held.
- ST_INIT: cfg MRS accepted → MRS on pins next cycle; cfg_rdy_o low for 12 cycles; ZQCL then accepted; cfg_rdy_o low for 512 cycles.
- Run: mem ACT ba=2, then cfg_ref_i=1:
  - PRE ba=0 adr=0x400 on pins.
  - REF issued 3 cycles after the PRE; ref_ack_o single pulse.
  - mem_ready_o=0 until 12 cycles after REF accept; open_banks=0.
- Run, all banks closed, cfg_ref_i=1 → REF issued directly, no PRE; ref_ack_o pulses once.
- mem_valid_i=1 and cfg_ref_i=1 in the same ST_IDLE cycle → refresh issues; mem command accepted only after ST_WRFC exits.
- Open-bank tracking: ACT ba=3, then RD ba=3 adr[10]=1, then cfg_ref_i → no PRE issued; REF issued directly.
